// File: rtl/fir_pkg.sv
// fir_pkg: shared definitions for the 1:4 polyphase interpolator.
//   - default sample widths (DATA_W_DEF, OUT_W_DEF)
//   - phase count, tap count, taps per phase, coefficient width
//   - the 16-tap coefficient set H (index = phase + 4*k)
//   - two-state FSM encoding
package fir_pkg;

  localparam int DATA_W_DEF     = 8;
  localparam int OUT_W_DEF      = 16;
  localparam int N_PHASES       = 4;
  localparam int N_TAPS         = 16;
  localparam int TAPS_PER_PHASE = N_TAPS / N_PHASES;
  localparam int COEF_W         = 8;
  localparam int PHASE_W        = 2;

  // Per-phase sum of |H[p+4k]| is at most 9, far below 255, so a full
  // precision 4-term sum of 16-bit products always fits in 16 bits.
  localparam logic signed [COEF_W-1:0] H [N_TAPS] = '{
    -8'sd2, -8'sd1, 8'sd3, 8'sd4,
     8'sd1,  8'sd1, 8'sd1, 8'sd1,
     8'sd1,  8'sd1, 8'sd1, 8'sd1,
     8'sd1,  8'sd1, 8'sd1, 8'sd1
  };

  typedef enum logic {
    ST_IDLE = 1'b0,   // no pending output
    ST_EMIT = 1'b1    // phase counter 0..3 is presenting an output
  } state_e;

endpackage

// File: rtl/fir_phase_mac.sv
// fir_phase_mac: combinational 4-term MAC for one output phase.
//   phase : current output phase (0..3), selects H[phase + 4*k]
//   taps  : delay line, taps[0] = newest sample x[n], taps[3] = x[n-3]
//   y     : sum of H[phase+4k]*taps[k], sign-extended, no rounding
module fir_phase_mac
  import fir_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OUT_W  = OUT_W_DEF
) (
  input  logic        [PHASE_W-1:0] phase,
  input  logic signed [DATA_W-1:0]  taps [TAPS_PER_PHASE],
  output logic signed [OUT_W-1:0]   y
);

  localparam int PROD_W = COEF_W + DATA_W;

  logic signed [PROD_W-1:0] prod     [TAPS_PER_PHASE];
  logic signed [OUT_W-1:0]  prod_ext [TAPS_PER_PHASE];

  generate
    for (genvar gi = 0; gi < TAPS_PER_PHASE; gi++) begin : g_tap
      localparam logic [3:0] BASE = 4'(gi * N_PHASES);
      logic signed [COEF_W-1:0] coef_sel;
      assign coef_sel     = H[BASE + {2'b00, phase}];
      assign prod[gi]     = coef_sel * taps[gi];
      // Signed size cast sign-extends the full product into OUT_W.
      assign prod_ext[gi] = OUT_W'(prod[gi]);
    end
  endgenerate

  always_comb begin
    y = '0;
    for (int k = 0; k < TAPS_PER_PHASE; k++) begin
      y = y + prod_ext[k];
    end
  end

endmodule

// File: rtl/fir_interp4.sv
// fir_interp4: 1:4 polyphase interpolator with valid/ready handshakes.
//   clk, rst_n           : clock, asynchronous active-low reset
//   xin, xin_valid       : input sample stream
//   xin_ready            : input accepted this cycle when also xin_valid
//   yout, yout_valid     : interpolated output stream (4 per input)
//   yout_ready           : downstream consumes yout this cycle
// Each accepted sample shifts the 4-deep delay line and starts four output
// phases; yout is computed purely from the registered delay line and phase.
module fir_interp4
  import fir_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OUT_W  = OUT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] xin,
  input  logic                     xin_valid,
  output logic                     xin_ready,
  output logic signed [OUT_W-1:0]  yout,
  output logic                     yout_valid,
  input  logic                     yout_ready
);

  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(N_PHASES - 1);

  state_e                    state_q, state_d;
  logic [PHASE_W-1:0]        phase_q, phase_d;
  logic signed [DATA_W-1:0]  dl_q [TAPS_PER_PHASE];
  logic signed [DATA_W-1:0]  dl_d [TAPS_PER_PHASE];
  logic                      accept;
  logic                      transfer;

  always_comb begin
    xin_ready  = 1'b0;
    yout_valid = 1'b0;
    state_d    = state_q;
    phase_d    = phase_q;
    dl_d       = dl_q;

    // rst_n gates ready so nothing is advertised while reset is held.
    case (state_q)
      ST_IDLE: xin_ready = rst_n;
      ST_EMIT: begin
        yout_valid = 1'b1;
        // A new sample is only taken as the last phase leaves, which keeps
        // the stream gap-free at one input per four outputs.
        xin_ready  = rst_n && (phase_q == LAST_PHASE) && yout_ready;
      end
      default: ;
    endcase

    accept   = xin_valid && xin_ready;
    transfer = yout_valid && yout_ready;

    if (transfer) begin
      if (phase_q != LAST_PHASE) begin
        phase_d = phase_q + PHASE_W'(1);
      end else begin
        state_d = ST_IDLE;
        phase_d = '0;
      end
    end

    // An accept overrides the return to IDLE in the same cycle.
    if (accept) begin
      state_d = ST_EMIT;
      phase_d = '0;
      dl_d[0] = xin;
      for (int k = 1; k < TAPS_PER_PHASE; k++) begin
        dl_d[k] = dl_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      for (int k = 0; k < TAPS_PER_PHASE; k++) begin
        dl_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      dl_q    <= dl_d;
    end
  end

  fir_phase_mac #(
    .DATA_W (DATA_W),
    .OUT_W  (OUT_W)
  ) u_mac (
    .phase (phase_q),
    .taps  (dl_q),
    .y     (yout)
  );

endmodule
